// File: rtl/bf16_mul_pkg.sv
// Shared types and constants for the BF16 multiplier arbiter.
package bf16_mul_pkg;
    localparam int N_REQ_MAX = 8;
    localparam int ID_W      = $clog2(N_REQ_MAX);
    localparam int BF16_W    = 16;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ_MAX-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ_MAX; i++)
            if (oh[i]) id = id | ID_W'(i);
        return id;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant from a request vector; round robin by default, lowest index
// wins when BF16_MUL_ARB_FIXED_PRIO_EN is defined (pointer removed).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
`ifdef BF16_MUL_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // isolate the lowest set bit
    assign gnt = req & (~req + N'(1));
`else
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr, ptr_nxt, idx;
    logic [PW:0]   sum;

    // scan from the far end down so the request closest to ptr wins last
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        sum     = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (req[idx]) begin
                gnt     = N'(1) << idx;
                ptr_nxt = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       ptr <= '0;
        else if (|gnt) ptr <= ptr_nxt;
    end
`endif
endmodule

// File: rtl/bf16_mul_arbiter.sv
// Shares one pipelined BF16 multiplier among N_REQ requesters with ID-tag
// steering of products. Arbitration policy set by BF16_MUL_ARB_FIXED_PRIO_EN.
module bf16_mul_arbiter
    import bf16_mul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [32*N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        res_valid,
    output logic [BF16_W*N_REQ-1:0] res_data,
    input  logic [N_REQ-1:0]        res_ready,
    output logic [2*BF16_W-1:0]     mul_in,
    output logic                    mul_stb,
    input  logic [BF16_W-1:0]       mul_z,
    input  logic                    mul_z_stb,
    output logic                    err_mismatch
);
    localparam int QW = $clog2(MUL_LAT) + 1;

    logic [N_REQ-1:0]             inflight, elig, gnt;
    logic [N_REQ-1:0][BF16_W-1:0] res_q;
    logic [2*BF16_W-1:0]          iss_data;
    logic [ID_W-1:0]              iss_id;
    logic [QW-1:0]                quiet_cnt;
    tag_t                         tag_pipe [MUL_LAT:0];
    tag_t                         cap;

    assign elig      = req_valid & ~(inflight | res_valid);
    assign req_ready = rst ? '0 : gnt;
    assign iss_id    = onehot_to_id(N_REQ_MAX'(req_ready));
    assign cap       = tag_pipe[MUL_LAT];
    assign res_data  = res_q;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (elig),
        .gnt (gnt)
    );

    always_comb begin
        iss_data = '0;
        for (int i = 0; i < N_REQ; i++)
            if (req_ready[i]) iss_data = req_data[32*i +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_stb <= 1'b0;
            mul_in  <= '0;
            for (int s = 0; s <= MUL_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            mul_stb     <= |req_ready;
            if (|req_ready) mul_in <= iss_data;
            tag_pipe[0] <= '{vld: |req_ready, id: iss_id};
            for (int s = 1; s <= MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    // busy keeps capture and release of the same slot in different cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= '0;
            res_valid <= '0;
            res_q     <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (cap.vld && cap.id == ID_W'(i)) begin
                    assert (!(res_valid[i] && res_ready[i]));
                    res_q[i]     <= mul_z;
                    res_valid[i] <= 1'b1;
                    inflight[i]  <= 1'b0;
                end else if (res_valid[i] && res_ready[i]) begin
                    res_valid[i] <= 1'b0;
                end
                if (req_ready[i]) inflight[i] <= 1'b1;
            end
        end
    end

    // strobes from operations dropped by reset drain out during the quiet window
    always_ff @(posedge clk) begin
        if (rst) begin
            err_mismatch <= 1'b0;
            quiet_cnt    <= QW'(MUL_LAT - 1);
        end else if (quiet_cnt != '0) begin
            quiet_cnt <= quiet_cnt - 1'b1;
        end else if (mul_z_stb != tag_pipe[MUL_LAT-1].vld) begin
            err_mismatch <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Bench for bf16_mul_arbiter: behavioural 3-cycle multiplier, per-requester
// result scoreboard, and scenario tasks for timing and arbitration order.
module tb_bf16_mul_arbiter;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_data  = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    res_valid;
    logic [16*N-1:0] res_data;
    logic [N-1:0]    res_ready = '0;
    logic [31:0]     mul_in;
    logic            mul_stb;
    logic [15:0]     mul_z;
    logic            mul_z_stb;
    logic            err_mismatch;
    logic            force_stb = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [N][$];
    logic [15:0] sb_want;

    always #5 clk = ~clk;

    bf16_mul_arbiter #(.N_REQ(N), .MUL_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .mul_in       (mul_in),
        .mul_stb      (mul_stb),
        .mul_z        (mul_z),
        .mul_z_stb    (mul_z_stb),
        .err_mismatch (err_mismatch)
    );

    // normal-range BF16 multiply, truncating
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [15:0] m;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
        m = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (m[15]) begin
            e++;
            m = m >> 1;
        end
        return {s, e[7:0], m[13:7]};
    endfunction

    function automatic logic [31:0] opnd(input int i, input int k);
        logic [15:0] a, b;
        a = {1'b0, 8'(120 + i), 7'(i * 19 + k * 7)};
        b = {1'b0, 8'(125 + k % 5), 7'(k * 13 + 3)};
        return {a, b};
    endfunction

    // multiplier model: strobe in c, z_stb in c+2, z in c+3; not reset by rst
    logic        st1 = 1'b0, st2 = 1'b0;
    logic [15:0] p1 = '0, p2 = '0, mz = '0;
    always @(posedge clk) begin
        st1 <= mul_stb;
        p1  <= bf16_mul(mul_in[31:16], mul_in[15:0]);
        st2 <= st1;
        p2  <= p1;
        mz  <= p2;
    end
    assign mul_z     = mz;
    assign mul_z_stb = st2 | force_stb;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i])
                    exp_q[i].push_back(bf16_mul(req_data[32*i+16 +: 16], req_data[32*i +: 16]));
                if (res_valid[i] && res_ready[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected req%0d: got %h want none", i, res_data[16*i +: 16]);
                    end else begin
                        sb_want = exp_q[i].pop_front();
                        if (res_data[16*i +: 16] !== sb_want) begin
                            errors++;
                            $display("FAIL sb_data req%0d: got %h want %h", i, res_data[16*i +: 16], sb_want);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain_check(input string name);
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL %s_drain req%0d: got %0d pending want 0", name, i, exp_q[i].size());
            end
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        res_ready = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (mul_stb !== 1'b0) begin errors++; $display("FAIL reset_mul_stb: got %b want 0", mul_stb); end
        checks++; if (mul_in !== '0) begin errors++; $display("FAIL reset_mul_in: got %h want 0", mul_in); end
        checks++; if (res_valid !== '0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_data !== '0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_mismatch); end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        res_ready = '1;
        req_data[31:0] = {16'h3FC0, 16'h4000};
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++; if (mul_stb !== 1'b1) begin errors++; $display("FAIL single_stb: got %b want 1", mul_stb); end
        checks++; if (mul_in !== 32'h3FC04000) begin errors++; $display("FAIL single_mul_in: got %h want 3fc04000", mul_in); end
        @(negedge clk);
        checks++; if (mul_stb !== 1'b0) begin errors++; $display("FAIL single_stb_pulse: got %b want 0", mul_stb); end
        repeat (2) @(negedge clk);
        checks++; if (res_valid !== '0) begin errors++; $display("FAIL single_early: got %b want 0", res_valid); end
        @(negedge clk);
        checks++; if (res_valid !== 4'b0001) begin errors++; $display("FAIL single_res_valid: got %b want 0001", res_valid); end
        checks++; if (res_data[15:0] !== 16'h4040) begin errors++; $display("FAIL single_res_data: got %h want 4040", res_data[15:0]); end
        drain_check("single");
    endtask

    task automatic test_contention();
        logic [N-1:0] g, want;
        int rnd [N];
        do_reset();
        res_ready = '1;
        for (int i = 0; i < N; i++) begin
            rnd[i] = 0;
            req_data[32*i +: 32] = opnd(i, 0);
        end
        req_valid = '1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            g = req_ready;
            want = (c % 6 < 4) ? N'(1 << (c % 6)) : '0;
            checks++; if (g !== want) begin errors++; $display("FAIL contention_c%0d: got %b want %b", c, g, want); end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (g[i]) begin
                    rnd[i]++;
                    req_data[32*i +: 32] = opnd(i, rnd[i]);
                end
        end
        drain_check("contention");
    endtask

    task automatic test_backpressure();
        int seq [22] = '{0, 1, 2, 3, -1, -1, 0, 1, -1, 3, -1, -1, 0, 1, -1, 3, -1, -1, 0, 1, -1, 2};
        logic [N-1:0] want;
        do_reset();
        res_ready = 4'b1011;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = opnd(i, 1);
        req_valid = '1;
        for (int c = 0; c < 22; c++) begin
            if (c == 20) res_ready = '1;
            @(negedge clk);
            want = (seq[c] < 0) ? '0 : N'(1 << seq[c]);
            checks++; if (req_ready !== want) begin errors++; $display("FAIL backpressure_c%0d: got %b want %b", c, req_ready, want); end
            if (c >= 7 && c < 20) begin
                checks++; if (res_valid[2] !== 1'b1) begin errors++; $display("FAIL backpressure_hold_c%0d: got %b want 1", c, res_valid[2]); end
            end
            @(posedge clk); #1;
        end
        drain_check("backpressure");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        res_ready = '1;
        req_data[63:32] = opnd(1, 2);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL midflight_ready: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (res_valid !== '0) begin errors++; $display("FAIL midflight_res_c%0d: got %b want 0", c, res_valid); end
            checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL midflight_err_c%0d: got %b want 0", c, err_mismatch); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stray_strobe();
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        force_stb = 1'b1;
        @(negedge clk);
        checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL stray_early: got %b want 0", err_mismatch); end
        @(posedge clk); #1;
        force_stb = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (err_mismatch !== 1'b1) begin errors++; $display("FAIL stray_sticky_c%0d: got %b want 1", c, err_mismatch); end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b want 0", err_mismatch); end
    endtask

    task automatic test_priority();
        logic [N-1:0] g, first, second;
`ifdef BF16_MUL_ARB_FIXED_PRIO_EN
        first = 4'b0010; second = 4'b1000;
`else
        first = 4'b1000; second = 4'b0010;
`endif
        do_reset();
        res_ready = '1;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = opnd(i, 3);
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL prio_seed: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b1010;
        @(negedge clk);
        g = req_ready;
        checks++; if (g !== first) begin errors++; $display("FAIL prio_first: got %b want %b", g, first); end
        @(posedge clk); #1;
        req_valid = req_valid & ~g;
        @(negedge clk);
        checks++; if (req_ready !== second) begin errors++; $display("FAIL prio_second: got %b want %b", req_ready, second); end
        @(posedge clk); #1;
        drain_check("prio");
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_midflight();
        test_stray_strobe();
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/bf16_mul_arbiter.md
# bf16_mul_arbiter

Shares one 3-stage BF16 multiplier pipeline among `N_REQ` requesters. Each requester has a valid/ready operand port and a valid/ready result port. The block grants the multiplier to one requester per cycle and tracks each in-flight operation with an ID tag pipeline. It steers every product back to the requester that issued it. The block sits between the probabilistic-circuit product nodes and the single shared multiplier instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2 to 8.
- `MUL_LAT`, 3: cycles from the multiplier strobe-in cycle to the cycle in which the multiplier `z` is valid.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, N_REQ: operand request per requester.
- `req_data`, in, 32·N_REQ: slice i is {a[15:0], b[15:0]}, both BF16.
- `req_ready`, out, N_REQ: operand accepted when valid&ready.
- `res_valid`, out, N_REQ: product available per requester.
- `res_data`, out, 16·N_REQ: BF16 product, slice i.
- `res_ready`, in, N_REQ: result consumed when valid&ready.
- `mul_in`, out, 32: to multiplier operand bus {a,b}.
- `mul_stb`, out, 1: to multiplier input strobe.
- `mul_z`, in, 16: multiplier product.
- `mul_z_stb`, in, 1: multiplier output strobe. It leads `mul_z` by one cycle.
- `err_mismatch`, out, 1: sticky flag for a tag/strobe disagreement.

## Operation
- Busy state per requester: `busy[i] = inflight[i] | res_valid[i]`. Each requester has at most one operation outstanding.
- Eligibility: `elig[i] = req_valid[i] & ~busy[i]`.
- Arbitration: a round-robin arbiter selects one eligible requester per cycle. The pointer advances to the granted index + 1 only on a grant.
- `req_ready[i]` is 1 only for the granted index. It is combinational from `elig` and the pointer.
- Issue: on a handshake, the block registers `mul_in` ← `req_data[i]` and sets `mul_stb` ← 1 for exactly one cycle. In the same edge it sets `inflight[i]` ← 1.
- Tag pipeline: MUL_LAT+1 entries of {vld, id}. An entry is shifted in alongside `mul_stb`.
- Capture: when the tag at depth MUL_LAT is valid, `mul_z` is written into `res_data[id]` and `res_valid[id]` ← 1. In the same edge `inflight[id]` ← 0.
- Result release: `res_valid[i]` clears on `res_valid[i] & res_ready[i]`.
- Strobe check: `mul_z_stb` must equal the tag valid bit at depth MUL_LAT−1.
  - On any disagreement, `err_mismatch` ← 1 and stays set until `rst`.
  - The capture path still uses the tag, never `mul_z_stb`.
- No backpressure toward the multiplier is needed: a capture slot is always free, because `busy` prevents issue to a requester whose result register is occupied.

## Timing
- Reset values, applied at the next edge:
  - `mul_stb`=0, `mul_in`=0.
  - `res_valid`=0, `res_data`=0.
  - `inflight`=0, all tags invalid.
  - RR pointer=0, `err_mismatch`=0.
  - `req_ready` is 0 while `rst`=1.
- Latency: handshake in cycle t, `mul_stb` in t+1, `mul_z_stb` in t+3, `mul_z` valid in t+4, capture at the end of t+4, `res_valid` from t+5.
- Re-issue: the same requester can be re-granted no earlier than t+6, when its result is consumed in t+5.
- Throughput: one grant per cycle across requesters. With `N_REQ`=4 and all `res_ready`=1, the pattern is 4 grants then 2 idle cycles, repeating.
- Reset mid-operation: all in-flight tags are dropped and their products are never delivered. Multiplier outputs arriving after reset are ignored and do not set `err_mismatch`.
- A capture for requester i and a `res_ready` handshake for the same i cannot occur in the same cycle, because `busy` rules it out. This is asserted in verification.

## Configuration
- `BF16_MUL_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where the lowest eligible index wins. The RR pointer is removed.
  - Undefined (default): round robin as described in Operation.

## Structure
- Shared package `bf16_mul_pkg` holds:
  - `N_REQ_MAX`=8.
  - `ID_W`=$clog2(N_REQ_MAX).
  - The tag struct {vld, id}.
  - `BF16_W`=16.
- Sub-module `rr_arbiter` (N-bit request vector → one-hot grant, pointer update on grant). It includes the fixed-priority variant under the macro.
- The tag pipeline, busy tracking and result registers stay in the top module.

## Test plan
- Single product: requester 0 sends a=0x3FC0, b=0x4000 at t → `mul_stb` at t+1, `res_valid[0]` at t+5 with `res_data[0]`=0x4040.
- Full contention: all 4 requesters continuously valid, `res_ready`=1 → grants 0,1,2,3 in t..t+3, then idle in t+4 and t+5, then 0 again at t+6. Every result matches its own operands.
- Backpressure: `res_ready[2]` held 0 for 20 cycles → requester 2 is granted once and `req_ready[2]` stays 0 until release. The others keep their round-robin order, skipping index 2.
- Reset mid-flight: `rst` is pulsed at t+2 after an issue at t → no `res_valid` ever appears for that operation, and `err_mismatch` stays 0.
- Stray strobe: force `mul_z_stb`=1 with no tag at depth MUL_LAT−1 → `err_mismatch` goes to 1 at the next edge and holds until `rst`.
- With `BF16_MUL_ARB_FIXED_PRIO_EN` defined: requesters 1 and 3 both valid → requester 1 is granted first, then 3.
